// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain controller.
//   state_t   : controller FSM states
//   cnt_width : width of the phase counter, wide enough to hold
//               max(chain length, capture cycles)
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_cycle_counter.sv
// Phase cycle counter for the scan controller.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to zero (takes priority over en)
//   en       : advance the count by one; saturates at limit, never wraps
//   limit    : programmable terminal value
//   tc       : count == limit
module scan_cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (en && !tc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign tc = (r_count == limit);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shifts a pattern into a chain of scan flops,
// runs CAPTURE_CYCLES functional clocks, shifts the captured state back out
// and compares it with an expected vector.
//   clk, rst                : clock (shared with chain), sync active-high reset
//   start_valid/start_ready : request handshake carrying pattern_in/expected_in
//   scan_en/scan_in         : chain se and flop-0 si
//   scan_out                : q of the last chain flop
//   busy                    : controller not idle
//   resp_valid/resp_ready   : response handshake carrying resp_data/mismatch
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = 8,
  parameter int unsigned CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 mismatch
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
  // Terminal values are "edges in phase minus one": tc is seen before the
  // last edge of the phase, so the transition lands exactly on that edge.
  localparam logic [CW-1:0] SHIFT_LIMIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LIMIT   = CW'(CAPTURE_CYCLES - 1);

  state_t               r_state;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_resp;
  logic [CHAIN_LEN-1:0] r_resp_data;
  logic                 r_scan_en;
  logic                 r_scan_in;
  logic                 r_resp_valid;
  logic                 r_mismatch;
  logic                 r_start_ready;
  logic                 r_busy;

  logic                 w_cnt_en;
  logic                 w_cnt_clr;
  logic                 w_tc;
  logic [CW-1:0]        w_limit;
  logic [CHAIN_LEN-1:0] w_resp_next;

  always_comb begin
    w_cnt_en  = (r_state == SHIFT_IN) || (r_state == CAPTURE) ||
                (r_state == SHIFT_OUT);
    w_limit   = (r_state == CAPTURE) ? CAP_LIMIT : SHIFT_LIMIT;
    // Clearing at the terminal edge reloads zero on every phase change.
    w_cnt_clr = !w_cnt_en || w_tc;
    w_resp_next    = r_resp << 1;
    w_resp_next[0] = scan_out;
  end

  scan_cycle_counter #(
    .WIDTH (CW)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_cnt_clr),
    .en    (w_cnt_en),
    .limit (w_limit),
    .tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pat         <= '0;
      r_exp         <= '0;
      r_resp        <= '0;
      r_resp_data   <= '0;
      r_scan_en     <= 1'b0;
      r_scan_in     <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_mismatch    <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            // MSB is presented right away; the rest queue up MSB-first.
            r_exp         <= expected_in;
            r_pat         <= pattern_in << 1;
            r_scan_in     <= pattern_in[CHAIN_LEN-1];
            r_scan_en     <= 1'b1;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (w_tc) begin
            r_scan_en <= 1'b0;
            r_scan_in <= 1'b0;
            r_state   <= CAPTURE;
          end else begin
            r_scan_in <= r_pat[CHAIN_LEN-1];
            r_pat     <= r_pat << 1;
          end
        end
        CAPTURE: begin
          if (w_tc) begin
            r_scan_en <= 1'b1;
            r_state   <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          // First sample is the last flop, so after N samples bit k = flop k.
          r_resp <= w_resp_next;
          if (w_tc) begin
            r_scan_en    <= 1'b0;
            r_resp_data  <= w_resp_next;
            r_mismatch   <= (w_resp_next != r_exp);
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign scan_en     = r_scan_en;
  assign scan_in     = r_scan_in;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign mismatch    = r_mismatch;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two controllers (CAPTURE_CYCLES = 1 and 2),
// each driving an 8-flop chain whose functional input is ~q.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sv   [2];
  logic       sr   [2];
  logic [7:0] pin  [2];
  logic [7:0] ein  [2];
  logic       se   [2];
  logic       si   [2];
  logic       so   [2];
  logic       bsy  [2];
  logic       rv   [2];
  logic       rr   [2];
  logic [7:0] rd   [2];
  logic       mm   [2];

  logic [7:0] q0, q1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
    .pattern_in(pin[0]), .expected_in(ein[0]), .scan_en(se[0]), .scan_in(si[0]),
    .scan_out(so[0]), .busy(bsy[0]), .resp_valid(rv[0]), .resp_ready(rr[0]),
    .resp_data(rd[0]), .mismatch(mm[0])
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
    .pattern_in(pin[1]), .expected_in(ein[1]), .scan_en(se[1]), .scan_in(si[1]),
    .scan_out(so[1]), .busy(bsy[1]), .resp_valid(rv[1]), .resp_ready(rr[1]),
    .resp_data(rd[1]), .mismatch(mm[1])
  );

  // Chains of scan flops: shift when se, otherwise load d = ~q.
  always @(posedge clk) begin
    if (se[0]) q0 <= {q0[6:0], si[0]}; else q0 <= ~q0;
    if (se[1]) q1 <= {q1[6:0], si[1]}; else q1 <= ~q1;
  end
  assign so[0] = q0[7];
  assign so[1] = q1[7];

  function automatic int capc(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Each capture clock inverts every flop once.
  function automatic logic [7:0] model_resp(input int d, input logic [7:0] pat);
    return (capc(d) % 2 == 1) ? ~pat : pat;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    chk("rst_scan_en", 64'(se[d]), 64'd0);
    chk("rst_scan_in", 64'(si[d]), 64'd0);
    chk("rst_resp_valid", 64'(rv[d]), 64'd0);
    chk("rst_mismatch", 64'(mm[d]), 64'd0);
    chk("rst_resp_data", 64'(rd[d]), 64'd0);
    chk("rst_start_ready", 64'(sr[d]), 64'd1);
    chk("rst_busy", 64'(bsy[d]), 64'd0);
  endtask

  // Called at a negedge. abort_at >= 0 asserts rst before the edge following
  // observation point abort_at and checks the reset values instead of a result.
  task automatic do_run(input int d, input logic [7:0] pat, input logic [7:0] exp,
                        input int hold, input int abort_at);
    int n;
    int j;
    int lat_exp;
    logic [63:0] se_h, si_h, se_e, si_e;
    logic [7:0] want;
    logic       want_mm;
    logic [7:0] held;
    n = 0;
    while (sr[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready", 64'(sr[d]), 64'd1);
    sv[d] = 1'b1; pin[d] = pat; ein[d] = exp;
    @(negedge clk);
    sv[d] = 1'b0; pin[d] = 8'($urandom); ein[d] = 8'($urandom);
    chk("busy_after_accept", 64'(bsy[d]), 64'd1);
    chk("ready_after_accept", 64'(sr[d]), 64'd0);
    lat_exp = 2 * N + capc(d);
    se_h = '0; si_h = '0; j = 0;
    while (rv[d] !== 1'b1 && j < 60) begin
      if (j == abort_at) begin
        rst = 1'b1;
        sv[d] = 1'b0;
        @(negedge clk);
        check_reset(d);
        rst = 1'b0;
        return;
      end
      se_h[j] = se[d];
      si_h[j] = si[d];
      // Requests while busy must be ignored.
      sv[d]  = (j >= 1 && j <= 3);
      pin[d] = 8'($urandom);
      ein[d] = 8'($urandom);
      @(negedge clk);
      j++;
    end
    sv[d] = 1'b0;
    se_e = '0; si_e = '0;
    for (int k = 0; k < lat_exp; k++) begin
      se_e[k] = (k < N || k >= N + capc(d));
      if (k < N) si_e[k] = pat[N-1-k];
    end
    want    = model_resp(d, pat);
    want_mm = (want != exp);
    chk("latency", 64'(j), 64'(lat_exp));
    chk("scan_en_seq", se_h, se_e);
    chk("scan_in_seq", si_h, si_e);
    chk("resp_data", 64'(rd[d]), 64'(want));
    chk("mismatch", 64'(mm[d]), 64'(want_mm));
    chk("scan_en_done", 64'(se[d]), 64'd0);
    held = rd[d];
    for (int h = 0; h < hold; h++) begin
      sv[d]  = 1'b1;
      pin[d] = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 64'(rv[d]), 64'd1);
      chk("hold_data", 64'(rd[d]), 64'(held));
      chk("hold_ready", 64'(sr[d]), 64'd0);
    end
    sv[d] = 1'b0;
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk("post_valid", 64'(rv[d]), 64'd0);
    chk("post_ready", 64'(sr[d]), 64'd1);
    chk("post_busy", 64'(bsy[d]), 64'd0);
    chk("post_data", 64'(rd[d]), 64'(want));
    chk("post_mismatch", 64'(mm[d]), 64'(want_mm));
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] e;
    int d;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; rr[k] = 1'b0; pin[k] = '0; ein[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    do_run(0, 8'hA5, 8'h5A, 0, -1);
    do_run(0, 8'hA5, 8'h00, 0, -1);
    do_run(0, 8'h71, 8'h8E, 5, -1);
    do_run(0, 8'h0F, 8'h0F, 0, -1);
    // rst lands on the 3rd SHIFT_OUT edge (edge 2N+C-? : N+1+3 = 12).
    do_run(0, 8'hC3, 8'h3C, 0, 11);
    do_run(0, 8'h96, 8'h69, 0, -1);
    do_run(1, 8'h3C, 8'h3C, 0, -1);
    do_run(1, 8'hFF, 8'h00, 2, -1);

    for (int r = 0; r < 12; r++) begin
      d = int'($urandom_range(0, 1));
      p = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? model_resp(d, p) : 8'($urandom);
      do_run(d, p, e, int'($urandom_range(0, 3)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
